counter_modn_updown: RTL and testbench

- Parametrised successor to the team's 4-bit ripple-enable counter.
- Generalised width and modulus, up/down direction, synchronous load and clear, optional saturation, and a sticky overflow flag.
- cout is a cascade carry/borrow, so instances chain into multi-digit counters (e.g. BCD timers) by feeding cout into the next stage's cin.

---
 rtl/counter_modn_updown.sv | 68 ++++++
 tb/tb_counter_modn_updown.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_modn_updown.sv
// Modulo-N up/down counter with synchronous load/clear, optional saturation,
// a sticky overflow flag and a combinational cascade carry/borrow out.
module counter_modn_updown #(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cin,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             ovf
);

  if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
    $error("counter_modn_updown: MODULO must lie in 2..2**WIDTH");
  end

  // Sized cast keeps MODULO = 2**WIDTH from truncating to zero.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] term_val;
  logic             at_term;

  assign term_val = up ? MAX_VAL : '0;
  assign at_term  = (count_q == term_val);

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = (d > MAX_VAL) ? MAX_VAL : d;
    end else if (cin) begin
      if (at_term) begin
        ovf_d = 1'b1;
        if (SATURATE == 0) count_d = up ? '0 : MAX_VAL;
      end else begin
        count_d = up ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Carry fires in the cycle before the wrap edge so the next digit steps with it.
  assign cout = cin & ~clr & ~load & at_term;
  assign q    = count_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_counter_modn_updown.sv
// Bench for counter_modn_updown: decade, saturating-decade and binary instances
// on shared inputs, plus a units->tens cascade built from the decade counter.
module tb_counter_modn_updown;

  logic       clk = 1'b0;
  logic       reset;
  logic       cin, up, load, clr;
  logic [3:0] d;

  logic [3:0] q10, q10s, q16, qt;
  logic       cout10, cout10s, cout16, coutt;
  logic       ovf10, ovf10s, ovf16, ovft;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  counter_modn_updown #(.WIDTH(4), .MODULO(10), .SATURATE(0)) u10 (
    .clk(clk), .reset(reset), .cin(cin), .up(up), .load(load), .d(d), .clr(clr),
    .q(q10), .cout(cout10), .ovf(ovf10));

  counter_modn_updown #(.WIDTH(4), .MODULO(10), .SATURATE(1)) u10s (
    .clk(clk), .reset(reset), .cin(cin), .up(up), .load(load), .d(d), .clr(clr),
    .q(q10s), .cout(cout10s), .ovf(ovf10s));

  counter_modn_updown #(.WIDTH(4), .MODULO(16), .SATURATE(0)) u16 (
    .clk(clk), .reset(reset), .cin(cin), .up(up), .load(load), .d(d), .clr(clr),
    .q(q16), .cout(cout16), .ovf(ovf16));

  counter_modn_updown #(.WIDTH(4), .MODULO(10), .SATURATE(0)) u_tens (
    .clk(clk), .reset(reset), .cin(cout10), .up(up), .load(1'b0), .d(4'd0), .clr(clr),
    .q(qt), .cout(coutt), .ovf(ovft));

  typedef struct {
    logic       clr, load, cin, up;
    logic [3:0] d;
    logic       exp_cout;
    logic [3:0] exp_q;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic c, input logic l, input logic ci, input logic u,
                        input logic [3:0] dv);
    clr  = c;
    load = l;
    cin  = ci;
    up   = u;
    d    = dv;
  endtask

  // Reference model: plain integer arithmetic on the counting rules.
  function automatic bit ref_cout(input int m, input int mq);
    return cin && !clr && !load && (mq == (up ? m - 1 : 0));
  endfunction

  task automatic ref_next(input int m, input bit sat, inout int mq, inout bit movf);
    int n;
    if (clr) begin
      mq   = 0;
      movf = 1'b0;
    end else if (load) begin
      mq = (int'(d) < m) ? int'(d) : m - 1;
    end else if (cin) begin
      n = up ? mq + 1 : mq - 1;
      if (n < 0 || n >= m) begin
        movf = 1'b1;
        if (!sat) mq = (n + m) % m;
      end else begin
        mq = n;
      end
    end
  endtask

  initial begin
    int  m10, m10s, m16;
    bit  o10, o10s, o16;

    //            clr   load  cin   up    d      cout  q      ovf
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 4'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 1'b0, 4'd9, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  1'b1, 4'd0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd5,  1'b0, 4'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd5,  1'b0, 4'd5, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd5, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd4, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 4'd9, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  1'b1, 4'd0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd9,  1'b0, 4'd9, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd8, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 1'b0, 4'd9, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd9, 1'b1};

    // Reset state
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    tick();
    check("reset_q10", q10, 0);
    check("reset_ovf10", ovf10, 0);
    check("reset_q16", q16, 0);
    check("reset_cout10", cout10, 0);
    reset = 1'b1;

    // Table vectors on the wrapping decade counter
    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i].clr, tbl[i].load, tbl[i].cin, tbl[i].up, tbl[i].d);
      #1;
      check($sformatf("tbl%0d_cout", i), cout10, tbl[i].exp_cout);
      tick();
      check($sformatf("tbl%0d_q", i), q10, tbl[i].exp_q);
      check($sformatf("tbl%0d_ovf", i), ovf10, tbl[i].exp_ovf);
    end

    // Asynchronous reset mid-count with ovf already set
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    repeat (7) tick();
    check("midrst_pre_q", q10, 6);
    check("midrst_pre_ovf", ovf10, 1);
    #2 reset = 1'b0;
    #1;
    check("midrst_async_q", q10, 0);
    check("midrst_async_ovf", ovf10, 0);
    #1 reset = 1'b1;
    tick();
    check("midrst_release_q", q10, 1);

    // Decade wrap from 0, up
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 12; i++) begin
      #1;
      check($sformatf("wrap%0d_cout", i), cout10, (i == 9));
      tick();
      check($sformatf("wrap%0d_q", i), q10, (i + 1) % 10);
      check($sformatf("wrap%0d_ovf", i), ovf10, (i >= 9));
    end

    // Down borrow vs saturation from q=2
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      int exp_w, exp_s;
      exp_w = (i == 0) ? 1 : (i == 1) ? 0 : (i == 2) ? 9 : 8;
      exp_s = (i == 0) ? 1 : 0;
      #1;
      check($sformatf("down%0d_cout_wrap", i), cout10, (i == 2));
      check($sformatf("down%0d_cout_sat", i), cout10s, (i >= 2));
      tick();
      check($sformatf("down%0d_q_wrap", i), q10, exp_w);
      check($sformatf("down%0d_q_sat", i), q10s, exp_s);
      check($sformatf("down%0d_ovf_sat", i), ovf10s, (i >= 2));
    end

    // Full binary range on the MODULO=16 instance
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 17; i++) begin
      #1;
      check($sformatf("bin%0d_cout", i), cout16, (i == 15));
      tick();
      check($sformatf("bin%0d_q", i), q16, (i + 1) % 16);
    end

    // Two-digit cascade
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    repeat (37) tick();
    check("casc37_tens", qt, 3);
    check("casc37_units", q10, 7);
    check("casc37_tens_ovf", ovft, 0);
    repeat (62) tick();
    check("casc99_tens", qt, 9);
    check("casc99_units", q10, 9);
    check("casc99_cout", coutt, 1);
    tick();
    check("casc00_tens", qt, 0);
    check("casc00_units", q10, 0);
    check("casc00_tens_ovf", ovft, 1);
    check("casc00_units_ovf", ovf10, 1);

    // Randomised traffic against the reference model
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    m10 = 0; m10s = 0; m16 = 0;
    o10 = 1'b0; o10s = 1'b0; o16 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)));
      #1;
      check($sformatf("rnd%0d_cout10", i), cout10, ref_cout(10, m10));
      check($sformatf("rnd%0d_cout10s", i), cout10s, ref_cout(10, m10s));
      check($sformatf("rnd%0d_cout16", i), cout16, ref_cout(16, m16));
      ref_next(10, 1'b0, m10, o10);
      ref_next(10, 1'b1, m10s, o10s);
      ref_next(16, 1'b0, m16, o16);
      tick();
      check($sformatf("rnd%0d_q10", i), q10, m10);
      check($sformatf("rnd%0d_q10s", i), q10s, m10s);
      check($sformatf("rnd%0d_q16", i), q16, m16);
      check($sformatf("rnd%0d_ovf10", i), ovf10, o10);
      check($sformatf("rnd%0d_ovf10s", i), ovf10s, o10s);
      check($sformatf("rnd%0d_ovf16", i), ovf16, o16);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
